adc_frame_packer: RTL and testbench

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

---
 rtl/adc_frame_packer.sv | 176 +++++++++++++++++
 tb/tb_adc_frame_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// Ping-pong store-and-forward framer: ADC beats in, header + payload (+ optional checksum trailer) out.
// Optional feature macro: ADC_FRAME_PACKER_CSUM_EN (adds a TRL beat carrying the payload sum).
//   state | meaning
//   IDLE  | waiting for the oldest bank to close
//   HDR   | presenting {frame_cnt, len}
//   PAY   | presenting payload words 0..len-1
//   TRL   | presenting the payload checksum (checksum build only)
module adc_frame_packer #(
  parameter int unsigned FRAME_WORDS    = 256,
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tvalid,
  input  logic        s00_axis_tlast,
  output logic        s00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic        m00_axis_tvalid,
  output logic        m00_axis_tlast,
  output logic [3:0]  m00_axis_tkeep,
  input  logic        m00_axis_tready,
  output logic [15:0] overflow_cnt
);
  localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} rd_state_e;

  logic [31:0] mem_q [2][FRAME_WORDS];
  logic [1:0]  full_q, full_d;
  logic [15:0] len_q [2];
  logic [15:0] len_d [2];
  logic        run_q;
  logic        wr_bank_q, wr_bank_d;
  logic [15:0] wr_len_q, wr_len_d;
  logic        rd_bank_q, rd_bank_d;
  logic [15:0] rd_idx_q, rd_idx_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] ovf_q, ovf_d;
  rd_state_e   state_q, state_d;
  logic        wr_fire, wr_close, pay_last, rd_done;
  logic [15:0] rd_len;
  logic [31:0] rd_word;
`ifdef ADC_FRAME_PACKER_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  // run_q delays tready to the first edge after reset release.
  assign s00_axis_tready = run_q & ~full_q[wr_bank_q];
  assign wr_fire         = s00_axis_tvalid & s00_axis_tready;
  assign wr_close        = wr_fire & (s00_axis_tlast | (wr_len_q == 16'(FRAME_WORDS - 1)));
  assign rd_len          = len_q[rd_bank_q];
  assign rd_word         = mem_q[rd_bank_q][rd_idx_q[AW-1:0]];
  assign pay_last        = (rd_idx_q == rd_len - 16'd1);
  assign m00_axis_tkeep  = 4'hf;
  assign overflow_cnt    = ovf_q;

  always_comb begin
    state_d         = state_q;
    rd_idx_d        = rd_idx_q;
    rd_bank_d       = rd_bank_q;
    frame_cnt_d     = frame_cnt_q;
    rd_done         = 1'b0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tdata  = 32'h0;
`ifdef ADC_FRAME_PACKER_CSUM_EN
    csum_d          = csum_q;
`endif
    case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = HDR;
      HDR: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = {frame_cnt_q, rd_len};
        if (m00_axis_tready) begin
          state_d  = PAY;
          rd_idx_d = 16'd0;
`ifdef ADC_FRAME_PACKER_CSUM_EN
          csum_d   = 32'h0;
`endif
        end
      end
      PAY: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = rd_word;
`ifdef ADC_FRAME_PACKER_CSUM_EN
        if (m00_axis_tready) begin
          csum_d   = csum_q + rd_word;
          rd_idx_d = rd_idx_q + 16'd1;
          if (pay_last) state_d = TRL;
        end
`else
        m00_axis_tlast  = pay_last;
        if (m00_axis_tready) begin
          rd_idx_d = rd_idx_q + 16'd1;
          if (pay_last) begin
            state_d = IDLE;
            rd_done = 1'b1;
          end
        end
`endif
      end
`ifdef ADC_FRAME_PACKER_CSUM_EN
      TRL: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tlast  = 1'b1;
        m00_axis_tdata  = csum_q;
        if (m00_axis_tready) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (rd_done) begin
      rd_bank_d   = ~rd_bank_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Close and free always target different banks, so both may land in one cycle.
  always_comb begin
    full_d    = full_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    wr_len_d  = wr_len_q;
    ovf_d     = ovf_q;
    if (wr_fire) wr_len_d = wr_len_q + 16'd1;
    if (wr_close) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = wr_len_q + 16'd1;
      wr_bank_d         = ~wr_bank_q;
      wr_len_d          = 16'd0;
    end
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (s00_axis_tvalid && !s00_axis_tready && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      run_q       <= 1'b0;
      full_q      <= 2'b00;
      len_q[0]    <= 16'd0;
      len_q[1]    <= 16'd0;
      wr_bank_q   <= 1'b0;
      wr_len_q    <= 16'd0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= 16'd0;
      frame_cnt_q <= FRAME_CNT_INIT;
      ovf_q       <= 16'd0;
      state_q     <= IDLE;
`ifdef ADC_FRAME_PACKER_CSUM_EN
      csum_q      <= 32'h0;
`endif
    end else begin
      run_q       <= 1'b1;
      full_q      <= full_d;
      len_q       <= len_d;
      wr_bank_q   <= wr_bank_d;
      wr_len_q    <= wr_len_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
`ifdef ADC_FRAME_PACKER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_len_q[AW-1:0]] <= s00_axis_tdata;
  end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: input beats feed a frame model, output beats pop and compare.
module tb_adc_frame_packer;
  localparam int          FW       = 4;
  localparam logic [15:0] CNT_INIT = 16'hFFF0;
`ifdef ADC_FRAME_PACKER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk, rst_n;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic        m_tvalid, m_tlast, m_tready;
  logic [3:0]  m_tkeep;
  logic [15:0] ovf;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;
  logic [32:0] exp_q[$];
  logic [31:0] cur[$];
  logic [15:0] cnt_m;
  bit          prev_stall, gap_arm;
  logic [32:0] prev_beat, exp_b;
  int          gap;

  adc_frame_packer #(.FRAME_WORDS(FW), .FRAME_CNT_INIT(CNT_INIT)) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tready (m_tready),
    .overflow_cnt    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] d, input logic l);
    logic [31:0] sum;
    int n;
    cur.push_back(d);
    if (l || cur.size() == FW) begin
      n = cur.size();
      sum = 32'h0;
      exp_q.push_back({1'b0, cnt_m, 16'(n)});
      for (int i = 0; i < n; i++) begin
        sum += cur[i];
        exp_q.push_back({(!CSUM && i == n - 1), cur[i]});
      end
      if (CSUM) exp_q.push_back({1'b1, sum});
      cur.delete();
      cnt_m++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
      if (gap_arm) begin
        if (m_tvalid) begin
          check("hdr_gap", gap <= 2, 1);
          gap_arm = 1'b0;
        end else gap++;
      end
      if (m_tvalid && m_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("beat", {m_tlast, m_tdata}, exp_b);
          if (exp_b[32] && exp_q.size() > 0) begin
            gap_arm = 1'b1;
            gap = 0;
          end
        end
      end
      if (s_tvalid && s_tready) model_push(s_tdata, s_tlast);
    end
  end

  task automatic apply_reset(input int cyc);
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = 32'h0;
    exp_q.delete();
    cur.delete();
    cnt_m = CNT_INIT;
    prev_stall = 1'b0;
    gap_arm = 1'b0;
    repeat (cyc) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_ovf", ovf, 0);
    check("tkeep", m_tkeep, 4'hf);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", s_tready, 0);
    @(negedge clk);
    check("rdy_first_edge", s_tready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || m_tvalid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          seen, tl;
    int          len;
    logic [15:0] ovf0;
    m_tready = 1'b1;
    apply_reset(3);

    // two full frames, no tlast
    for (int i = 0; i < 8; i++) send(32'(i), 1'b0);
    drain();

    // short frame closed by tlast, header latency from idle
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      @(negedge clk);
      seen = m_tvalid;
    end
    check("hdr_latency", seen, 1);
    drain();

    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    send(32'h4, 1'b0);
    drain();

    // output blocked: both banks fill, then input stalls are counted
    rdy_mode = 2;
    @(posedge clk);
    #1;
    ovf0 = ovf;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'b0);
    s_tdata = 32'h108;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("stall_tready", s_tready, 0);
    check("ovf_count", ovf - ovf0, 12);
    rdy_mode = 0;
    send(32'h108, 1'b0);
    send(32'h109, 1'b0);
    send(32'h10A, 1'b0);
    send(32'h10B, 1'b1);
    drain();

    // reset mid-frame discards the partial frame
    send(32'h55, 1'b0);
    send(32'h66, 1'b0);
    apply_reset(2);
    repeat (5) @(posedge clk);
    #1;
    check("no_out_after_rst", m_tvalid, 0);
    for (int i = 5; i <= 8; i++) send(32'(i), 1'b0);
    drain();

    // random backpressure, frame counter wraps past FFFF
    rdy_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, FW);
      tl = (len < FW) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) send($urandom, (j == len - 1) ? tl : 1'b0);
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
